// File: rtl/bcd_countdown_timer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | bcd_countdown_timer: loadable multi-digit BCD down-counter with        |
// | start/pause/expire control.                          Rev 1.0           |
// +------------------------------------------------------------------------+
module bcd_countdown_timer #(
  parameter  int NUM_DIGITS = 4,
  localparam int WIDTH      = 4 * NUM_DIGITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  input  logic             tick,
  output logic [WIDTH-1:0] count,
  output logic [1:0]       state,
  output logic             done,
  output logic             clamped
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUNNING = 2'd1,
    S_PAUSED  = 2'd2,
    S_EXPIRED = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             done_q, done_d;
  logic             clamped_q, clamped_d;

  logic [WIDTH-1:0]      w_load_sat;
  logic [NUM_DIGITS-1:0] w_digit_over;
  logic [WIDTH-1:0]      w_dec;

  // Saturate each incoming digit so the count can never hold a non-BCD value.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_clamp
    assign w_digit_over[g]      = (load_val[4*g +: 4] > 4'd9);
    assign w_load_sat[4*g +: 4] = w_digit_over[g] ? 4'd9 : load_val[4*g +: 4];
  end

  always_comb begin
    logic       borrow;
    logic [3:0] digit;
    w_dec  = count_q;
    borrow = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      digit = count_q[4*i +: 4];
      if (borrow) begin
        if (digit == 4'd0) begin
          w_dec[4*i +: 4] = 4'd9;
        end else begin
          w_dec[4*i +: 4] = digit - 4'd1;
          borrow          = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      done_q    <= 1'b0;
      clamped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      done_q    <= done_d;
      clamped_q <= clamped_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    done_d    = 1'b0;
    clamped_d = 1'b0;
    if (load) begin
      count_d   = w_load_sat;
      clamped_d = |w_digit_over;
      state_d   = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (!pause && start && (count_q != '0)) begin
            state_d = S_RUNNING;
          end
        end
        S_RUNNING: begin
          // A zero count here would otherwise wrap to all nines.
          if (count_q == '0) begin
            state_d = S_EXPIRED;
          end else if (pause) begin
            state_d = S_PAUSED;
          end else if (tick) begin
            count_d = w_dec;
            if (w_dec == '0) begin
              state_d = S_EXPIRED;
              done_d  = 1'b1;
            end
          end
        end
        S_PAUSED: begin
          if (!pause && start) begin
            state_d = S_RUNNING;
          end
        end
        S_EXPIRED: begin
          count_d = '0;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign count   = count_q;
  assign state   = state_q;
  assign done    = done_q;
  assign clamped = clamped_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_countdown_timer.sv
`default_nettype none
// tb_bcd_countdown_timer: directed vectors against a 4-digit and a 1-digit timer.
module tb_bcd_countdown_timer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_load, a_start, a_pause, a_tick;
  logic [15:0] a_val;
  logic [15:0] a_count;
  logic [1:0]  a_state;
  logic        a_done, a_clamped;

  logic        b_load, b_start, b_pause, b_tick;
  logic [3:0]  b_val;
  logic [3:0]  b_count;
  logic [1:0]  b_state;
  logic        b_done, b_clamped;

  int total = 0;
  int bad   = 0;
  int dcount;

  bcd_countdown_timer #(.NUM_DIGITS(4)) u_dut_a (
    .clk(clk), .rst(rst), .load(a_load), .load_val(a_val),
    .start(a_start), .pause(a_pause), .tick(a_tick),
    .count(a_count), .state(a_state), .done(a_done), .clamped(a_clamped)
  );

  bcd_countdown_timer #(.NUM_DIGITS(1)) u_dut_b (
    .clk(clk), .rst(rst), .load(b_load), .load_val(b_val),
    .start(b_start), .pause(b_pause), .tick(b_tick),
    .count(b_count), .state(b_state), .done(b_done), .clamped(b_clamped)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_load_val(input logic [15:0] v);
    a_load = 1'b1;
    a_val  = v;
    step();
    a_load = 1'b0;
  endtask

  task automatic a_pulse_start();
    a_start = 1'b1;
    step();
    a_start = 1'b0;
  endtask

  task automatic a_pulse_tick();
    a_tick = 1'b1;
    step();
    a_tick = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    a_load = 1'b0; a_start = 1'b0; a_pause = 1'b0; a_tick = 1'b0; a_val = 16'h0;
    b_load = 1'b0; b_start = 1'b0; b_pause = 1'b0; b_tick = 1'b0; b_val = 4'h0;
    step();
    a_start = 1'b1; a_tick = 1'b1;
    step();
    a_start = 1'b0; a_tick = 1'b0;
    chk("rst_count", 32'(a_count), 32'h0);
    chk("rst_state", 32'(a_state), 32'd0);
    chk("rst_done", 32'(a_done), 32'd0);
    chk("rst_clamped", 32'(a_clamped), 32'd0);
    rst = 1'b1;

    // Zero count must not start
    a_pulse_start();
    chk("zero_start_state", 32'(a_state), 32'd0);

    // Basic countdown 3 -> 0
    a_load_val(16'h0003);
    chk("load3_count", 32'(a_count), 32'h0003);
    chk("load3_state", 32'(a_state), 32'd0);
    a_pulse_tick();
    chk("idle_tick_ignored", 32'(a_count), 32'h0003);
    a_pulse_start();
    chk("start_state", 32'(a_state), 32'd1);
    a_pulse_tick();
    chk("cnt_2", 32'(a_count), 32'h0002);
    chk("cnt_2_done", 32'(a_done), 32'd0);
    a_pulse_tick();
    chk("cnt_1", 32'(a_count), 32'h0001);
    a_pulse_tick();
    chk("cnt_0", 32'(a_count), 32'h0000);
    chk("cnt_0_done", 32'(a_done), 32'd1);
    chk("cnt_0_state", 32'(a_state), 32'd3);
    step();
    chk("done_one_cycle", 32'(a_done), 32'd0);

    // Expired holds at zero regardless of tick/start/pause
    dcount = 0;
    for (int i = 0; i < 10; i++) begin
      a_tick  = 1'b1;
      a_start = (i == 9);
      a_pause = (i == 5);
      step();
      if (a_done) dcount++;
    end
    a_tick = 1'b0; a_start = 1'b0; a_pause = 1'b0;
    chk("exp_count", 32'(a_count), 32'h0000);
    chk("exp_state", 32'(a_state), 32'd3);
    chk("exp_no_done", 32'(dcount), 32'd0);

    // Borrow ripple across all digits
    a_load_val(16'h1000);
    chk("ripple_load_state", 32'(a_state), 32'd0);
    a_pulse_start();
    a_pulse_tick();
    chk("ripple_first", 32'(a_count), 32'h0999);
    dcount = 0;
    a_tick = 1'b1;
    for (int i = 0; i < 999; i++) begin
      step();
      if (a_done) dcount++;
      if (i == 498) chk("ripple_mid", 32'(a_count), 32'h0500);
    end
    a_tick = 1'b0;
    chk("ripple_end", 32'(a_count), 32'h0000);
    chk("ripple_state", 32'(a_state), 32'd3);
    chk("ripple_done_cnt", 32'(dcount), 32'd1);

    // Pause and resume
    a_load_val(16'h0050);
    a_pulse_start();
    for (int i = 0; i < 5; i++) a_pulse_tick();
    chk("pr_45", 32'(a_count), 32'h0045);
    a_pause = 1'b1;
    step();
    a_pause = 1'b0;
    chk("pr_paused", 32'(a_state), 32'd2);
    for (int i = 0; i < 3; i++) a_pulse_tick();
    chk("pr_held", 32'(a_count), 32'h0045);
    chk("pr_held_state", 32'(a_state), 32'd2);
    a_pulse_start();
    chk("pr_resume", 32'(a_state), 32'd1);
    a_pulse_tick();
    chk("pr_44", 32'(a_count), 32'h0044);

    // start+pause resolves as pause
    a_start = 1'b1; a_pause = 1'b1; a_tick = 1'b1;
    step();
    chk("sp_run_to_pause", 32'(a_state), 32'd2);
    chk("sp_no_tick", 32'(a_count), 32'h0044);
    step();
    a_start = 1'b0; a_pause = 1'b0; a_tick = 1'b0;
    chk("sp_stay_paused", 32'(a_state), 32'd2);
    a_pulse_start();

    // Load beats tick while running
    a_load = 1'b1; a_tick = 1'b1; a_val = 16'h0777;
    step();
    a_load = 1'b0; a_tick = 1'b0;
    chk("ld_tick_count", 32'(a_count), 32'h0777);
    chk("ld_tick_state", 32'(a_state), 32'd0);
    chk("ld_tick_clamped", 32'(a_clamped), 32'd0);

    // Clamping
    a_load_val(16'h1A3F);
    chk("clamp_count", 32'(a_count), 32'h1939);
    chk("clamp_pulse", 32'(a_clamped), 32'd1);
    step();
    chk("clamp_one_cycle", 32'(a_clamped), 32'd0);

    // Start+pause in idle stays idle
    a_start = 1'b1; a_pause = 1'b1;
    step();
    a_start = 1'b0; a_pause = 1'b0;
    chk("sp_idle", 32'(a_state), 32'd0);

    // Reset mid-run
    a_load_val(16'h0042);
    a_pulse_start();
    chk("mid_run_state", 32'(a_state), 32'd1);
    rst = 1'b0; a_tick = 1'b1;
    step();
    rst = 1'b1; a_tick = 1'b0;
    chk("mid_rst_count", 32'(a_count), 32'h0);
    chk("mid_rst_state", 32'(a_state), 32'd0);
    chk("mid_rst_done", 32'(a_done), 32'd0);
    a_pulse_tick();
    chk("post_rst_idle", 32'(a_state), 32'd0);

    // Single-digit instance
    b_load = 1'b1; b_val = 4'hC;
    step();
    chk("b_clamp_count", 32'(b_count), 32'h9);
    chk("b_clamp_pulse", 32'(b_clamped), 32'd1);
    b_val = 4'h9;
    step();
    b_load = 1'b0;
    chk("b_load9", 32'(b_count), 32'h9);
    chk("b_load9_clamped", 32'(b_clamped), 32'd0);
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    chk("b_start", 32'(b_state), 32'd1);
    for (int i = 0; i < 9; i++) begin
      b_tick = 1'b1;
      step();
      chk("b_count", 32'(b_count), 32'(8 - i));
      chk("b_done", 32'(b_done), (i == 8) ? 32'd1 : 32'd0);
    end
    b_tick = 1'b0;
    chk("b_state_exp", 32'(b_state), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
